// File: rtl/sample_capture_if.sv
// Handshake, sample and memory-write-port signals of the capture controller.
// slave: the controller itself; master: the block that drives and observes it.
interface sample_capture_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH:0]   num_samples;
    logic                  trigger;
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_en;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   sample_count;

    modport master (
        output start, abort, num_samples, trigger, sample_valid, sample_data,
        input  mem_addr, mem_wr_data, mem_wr_en, busy, done, sample_count
    );

    modport slave (
        input  start, abort, num_samples, trigger, sample_valid, sample_data,
        output mem_addr, mem_wr_data, mem_wr_en, busy, done, sample_count
    );
endinterface

// File: rtl/sample_capture_ctrl.sv
// Triggered ADC capture into memory port A with length clamp, abort and restart.
// Define DECIMATE_EN to accept only every DECIM-th valid sample during capture.
module sample_capture_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16,
    parameter int DECIM      = 4
) (
    input  logic            clk,
    input  logic            rst,
    sample_capture_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

`ifdef DECIMATE_EN
    localparam bit DecimOn = 1'b1;
`else
    localparam bit DecimOn = 1'b0;
`endif
    // Terminal decimation count; zero makes every valid sample in the window eligible.
    localparam logic [7:0] DecimLast = DecimOn ? 8'(DECIM - 1) : 8'd0;
    localparam logic [ADDR_WIDTH:0]   CntOne = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic                  start_ok;
    logic                  win_vld;
    logic                  accept;
    logic                  last;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0]            dec_cnt;
    logic                  wr_vld_p1;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [DATA_WIDTH-1:0] wr_data_p1;

    // Saturate a requested length to the memory depth so the pointer never wraps.
    function automatic logic [ADDR_WIDTH:0] sat_len(input logic [ADDR_WIDTH:0] n);
        logic [ADDR_WIDTH:0] depth;
        depth             = '0;
        depth[ADDR_WIDTH] = 1'b1;
        return (n > depth) ? depth : n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        win_vld   = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start && (bus.num_samples != '0)) begin
                        start_ok  = 1'b1;
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (bus.trigger) begin
                        state_nxt = CAPTURE;
                        win_vld   = bus.sample_valid;
                    end
                end
                CAPTURE: begin
                    win_vld = bus.sample_valid;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        accept = win_vld && (dec_cnt == 8'd0);
        last   = accept && ((count + CntOne) == len);
        if (last) begin
            state_nxt = DONE;
        end
    end

    // Stage p1: accepted sample becomes a registered write; pointer and count advance with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            len        <= '0;
            count      <= '0;
            ptr        <= '0;
            dec_cnt    <= 8'd0;
        end else begin
            wr_vld_p1 <= accept;
            if (start_ok) begin
                len     <= sat_len(bus.num_samples);
                count   <= '0;
                ptr     <= '0;
                dec_cnt <= 8'd0;
            end
            if (win_vld) begin
                dec_cnt <= (dec_cnt == DecimLast) ? 8'd0 : dec_cnt + 8'd1;
            end
            if (accept) begin
                wr_addr_p1 <= ptr;
                wr_data_p1 <= bus.sample_data;
                ptr        <= ptr + PtrOne;
                count      <= count + CntOne;
            end
        end
    end

    assign bus.mem_wr_en    = wr_vld_p1;
    assign bus.mem_addr     = wr_addr_p1;
    assign bus.mem_wr_data  = wr_data_p1;
    assign bus.sample_count = count;
    assign bus.busy         = (state == ARMED) || (state == CAPTURE);
    assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Randomised and directed bench for sample_capture_ctrl against a transaction-level model
// that predicts every memory write (cycle, address, data) and the busy/done/count status.
module tb_sample_capture_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DECIM = 4;
    localparam int DEPTH = 1 << AW;
`ifdef DECIMATE_EN
    localparam int DEC_EFF = DECIM;
`else
    localparam int DEC_EFF = 1;
`endif

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    wr_t  obs[$];
    wr_t  exp_q[$];

    // Reference state: capture in progress, trigger seen, finished, length, writes so far, valids seen.
    bit m_busy, m_trig, m_done;
    int m_len, m_acc, m_dec;

    sample_capture_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sample_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DECIM(DECIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1)
            obs.push_back('{cyc, int'(bus.mem_addr), int'(bus.mem_wr_data)});
    end

    task automatic check_eq(input string tag, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    function automatic void model_reset();
        m_busy = 1'b0;
        m_trig = 1'b0;
        m_done = 1'b0;
        m_len  = 0;
        m_acc  = 0;
        m_dec  = 0;
    endfunction

    // One clock of stimulus; stamp is the edge whose write would appear on the port.
    function automatic void model_cycle(input bit st, input int num, input bit trg, input bit vld,
                                        input int data, input bit abt, input int stamp);
        if (abt) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!m_busy) begin
            if (st && num != 0) begin
                m_busy = 1'b1;
                m_trig = 1'b0;
                m_done = 1'b0;
                m_len  = (num > DEPTH) ? DEPTH : num;
                m_acc  = 0;
                m_dec  = 0;
            end
        end else if (m_trig || trg) begin
            m_trig = 1'b1;
            if (vld) begin
                if (m_dec % DEC_EFF == 0) begin
                    exp_q.push_back('{stamp, m_acc, data});
                    m_acc++;
                    if (m_acc == m_len) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
                m_dec++;
            end
        end
    endfunction

    task automatic cycle(input bit st, input int num, input bit trg, input bit vld,
                         input int data, input bit abt);
        bus.start        = st;
        bus.num_samples  = (AW + 1)'(num);
        bus.trigger      = trg;
        bus.sample_valid = vld;
        bus.sample_data  = DW'(data);
        bus.abort        = abt;
        model_cycle(st, num, trg, vld, data, abt, cyc + 1);
        @(posedge clk);
        #1;
        check_eq("busy", longint'(bus.busy), longint'(m_busy));
        check_eq("done", longint'(bus.done), longint'(m_done));
        check_eq("sample_count", longint'(bus.sample_count), longint'(m_acc));
    endtask

    task automatic settle();
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_nwr"}, longint'(obs.size()), longint'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check_eq({tag, "_wr_cyc"}, longint'(obs[i].cyc), longint'(exp_q[i].cyc));
            check_eq({tag, "_wr_addr"}, longint'(obs[i].addr), longint'(exp_q[i].addr));
            check_eq({tag, "_wr_data"}, longint'(obs[i].data), longint'(exp_q[i].data));
        end
        obs.delete();
        exp_q.delete();
    endtask

    int n, pv, gap, abort_at, reps;
    bit do_abort;

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.num_samples  = '0;
        bus.trigger      = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_wr_en", longint'(bus.mem_wr_en), 0);
        check_eq("rst_addr", longint'(bus.mem_addr), 0);
        check_eq("rst_data", longint'(bus.mem_wr_data), 0);
        check_eq("rst_busy", longint'(bus.busy), 0);
        check_eq("rst_done", longint'(bus.done), 0);
        check_eq("rst_count", longint'(bus.sample_count), 0);
        rst = 1'b0;
        cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

        // Basic capture of four consecutive samples.
        cycle(1'b1, 4, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4 * DEC_EFF; i++) cycle(1'b0, 0, 1'b0, 1'b1, 'hA0 + i, 1'b0);
        settle();
        compare_writes("basic");
        check_eq("basic_done", longint'(bus.done), 1);
        check_eq("basic_count", longint'(bus.sample_count), 4);

        // Gapped valid, every third cycle.
        cycle(1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 9 * DEC_EFF + 3; i++) cycle(1'b0, 0, 1'b0, (i % 3) == 0, 'hB0 + i, 1'b0);
        settle();
        compare_writes("gap");
        check_eq("gap_done", longint'(bus.done), 1);

        // Abort after two of eight samples.
        cycle(1'b1, 8, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 'h10, 1'b0);
        for (int i = 1; i < 2 * DEC_EFF; i++) cycle(1'b0, 0, 1'b0, 1'b1, 'h10 + i, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 'h1F, 1'b1);
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1, 'h20, 1'b0);
        settle();
        compare_writes("abort");
        check_eq("abort_busy", longint'(bus.busy), 0);
        check_eq("abort_done", longint'(bus.done), 0);
        check_eq("abort_count", longint'(bus.sample_count), 2);

        // Ignored start with zero length, and trigger while idle.
        cycle(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
        check_eq("zero_len_busy", longint'(bus.busy), 0);
        cycle(1'b0, 0, 1'b1, 1'b1, 'h55, 1'b0);
        settle();
        check_eq("idle_trig_nwr", longint'(obs.size()), 0);
        compare_writes("ignored");

        // Clamp to memory depth, then restart from DONE with a start ignored while armed.
        cycle(1'b1, DEPTH + 5, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < DEPTH * DEC_EFF + 8; i++) cycle(1'b0, 0, 1'b0, 1'b1, 'hC00 + i, 1'b0);
        settle();
        check_eq("clamp_nwr", longint'(obs.size()), DEPTH);
        if (obs.size() > 0) check_eq("clamp_last_addr", longint'(obs[obs.size() - 1].addr), DEPTH - 1);
        check_eq("clamp_done", longint'(bus.done), 1);
        compare_writes("clamp");
        cycle(1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 'hD0, 1'b0);
        for (int i = 1; i < 3 * DEC_EFF + 2; i++) cycle(1'b0, 0, 1'b0, 1'b1, 'hD0 + i, 1'b0);
        settle();
        if (obs.size() > 0) check_eq("restart_first_addr", longint'(obs[0].addr), 0);
        check_eq("restart_count", longint'(bus.sample_count), 3);
        compare_writes("restart");

        // Reset mid-capture stops writes immediately and needs a fresh start.
        cycle(1'b1, 8, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 'hE0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 'hE1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 'hE2, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("midrst_wr_en", longint'(bus.mem_wr_en), 0);
        check_eq("midrst_busy", longint'(bus.busy), 0);
        check_eq("midrst_count", longint'(bus.sample_count), 0);
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc >= cyc) void'(exp_q.pop_back());
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 0, 1'b1, 1'b1, 'hE7, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1, 'hE8, 1'b0);
        settle();
        compare_writes("reset");

        // Randomised captures with gaps, stray starts/triggers and occasional aborts.
        for (int s = 0; s < 30; s++) begin
            n        = $urandom_range(0, 2 * DEPTH - 1);
            pv       = $urandom_range(1, 4);
            gap      = $urandom_range(0, 3);
            do_abort = ($urandom_range(0, 4) == 0);
            abort_at = $urandom_range(0, 30);
            reps     = 2 * DEPTH * DEC_EFF + 8;
            cycle(1'b1, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 65535)), 1'b0);
            for (int g = 0; g < gap; g++)
                cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 2 * DEPTH - 1)), 1'b0,
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'b0);
            cycle(1'b0, 0, 1'b1, $urandom_range(1, 4) <= pv, int'($urandom_range(0, 65535)), 1'b0);
            for (int i = 0; i < reps; i++)
                cycle($urandom_range(0, 15) == 0, int'($urandom_range(0, 2 * DEPTH - 1)),
                      1'($urandom_range(0, 1)), $urandom_range(1, 4) <= pv,
                      int'($urandom_range(0, 65535)), do_abort && (i == abort_at));
            if (m_busy) cycle(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
            settle();
            compare_writes("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
